lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8, state width in bits; legal range 3..16.
REQ-002 Parameter STEPS, default 1, single LFSR steps applied per accepted word; legal range 1..WIDTH.
REQ-003 Parameter DEFAULT_SEED, default 0, WIDTH-bit state used at reset and as substitute for an illegal seed.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  permits raising out_valid and keeping it raised after a transfer.
REQ-007 load  input  1  seed load strobe; highest priority after reset.
REQ-008 seed  input  WIDTH  seed value sampled when load=1.
REQ-009 out_data  output  WIDTH  current LFSR state (bit 0 = newest bit).
REQ-010 out_valid  output  1  out_data holds a word offered to the consumer.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-012 wrap  output  1  one-cycle pulse: the state returned to the last loaded seed.
REQ-013 lockup  output  1  one-cycle pulse: a loaded seed was all-ones and was replaced.

Function
REQ-014 Single step SHALL be: state <= {state[WIDTH-2:0], fb}, where fb = NOT(XOR of the tap bits); tap n means state bit n-1.
REQ-015 Tap sets SHALL be selected by WIDTH: 3:{3,2} 4:{4,3} 5:{5,3} 6:{6,5} 7:{7,6} 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9} 12:{12,6,4,1} 13:{13,4,3,1} 14:{14,5,3,1} 15:{15,14} 16:{16,15,13,4}.
REQ-016 An out-of-range WIDTH or STEPS SHALL cause an elaboration-time error.
REQ-017 The all-ones state is the lockup state; it SHALL never be entered through load or through DEFAULT_SEED.
REQ-018 A transfer (fire) SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-019 On fire, the state SHALL advance by exactly STEPS single steps in that one clock (unrolled, no extra latency).
REQ-020 While out_valid=1 and no fire occurs, out_data SHALL remain stable (load and reset excepted).
REQ-021 out_valid SHALL rise on the edge after any cycle with out_valid=0, enable=1, load=0 and reset=0.
REQ-022 On fire with enable=1, out_valid SHALL stay 1 and the new state is offered on the next cycle.
REQ-023 On fire with enable=0, the state SHALL advance and out_valid SHALL drop to 0.
REQ-024 enable=0 with no fire SHALL hold both the state and out_valid.
REQ-025 load=1 SHALL override everything else. The state and the reference seed SHALL take seed, or DEFAULT_SEED if seed is all-ones. out_valid SHALL clear. No advance SHALL occur, even if a fire coincides.
REQ-026 lockup SHALL pulse on the edge after any load whose seed is all-ones.
REQ-027 wrap SHALL pulse for one cycle, registered, whenever a fire produces a next state equal to the reference seed.
REQ-028 wrap SHALL report only state equality; when STEPS does not divide the period, it pulses only when alignment permits.

Reset
REQ-029 With reset=1 at a clock edge, the following SHALL apply:
- state and reference seed SHALL become DEFAULT_SEED.
- out_valid, wrap and lockup SHALL become 0.
REQ-030 reset SHALL take priority over load and fire; reset mid-stream discards the pending word.
REQ-031 If DEFAULT_SEED is all-ones, elaboration SHALL fail.

Verification
REQ-032 WIDTH=8, STEPS=1, reset, then enable=1 and out_ready=1 held -> out_valid rises one cycle after reset falls; out_data runs 0x00,0x01,0x03,0x07,0x0F,0x1E.
REQ-033 WIDTH=8, STEPS=1, continuous fire from seed 0x00 -> wrap pulses after exactly 255 fires; 0xFF is never observed.
REQ-034 WIDTH=8, STEPS=4, seed 0x00 loaded, single fire -> out_data goes 0x00 to 0x0F in one fire.
REQ-035 Load seed=0xFF (WIDTH=8, DEFAULT_SEED=0x00) -> lockup pulses once; out_data=0x00; out_valid=0 for one cycle, then 1 if enable=1.
REQ-036 Backpressure: out_ready=0 for 10 cycles with out_valid=1 -> out_data stable; then out_ready=1 with enable=0 -> one advance, out_valid drops to 0.
REQ-037 WIDTH=4, STEPS=1 and WIDTH=16, STEPS=1 free-run -> wrap after 15 and 65535 fires respectively, with no repeated state before wrap.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: XNOR-feedback Fibonacci LFSR word generator with a valid/ready output.
//
// Each accepted word (out_valid & out_ready) advances the state by STEPS single
// steps in one clock. A seed can be loaded at any time, and a seed equal to the
// all-ones lockup state is replaced by DEFAULT_SEED. wrap pulses when the state
// returns to the last loaded seed.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   enable     allows out_valid to rise and to stay high after a transfer
//   load       seed load strobe (highest priority after reset)
//   seed       seed value taken when load=1
//   out_data   current LFSR state (bit 0 = newest bit)
//   out_valid  out_data is offered to the consumer
//   out_ready  consumer accepts out_data when out_valid=1
//   wrap       one-cycle pulse: state came back to the reference seed
//   lockup     one-cycle pulse: an all-ones seed was loaded and replaced
module lfsr_gen #(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      STEPS        = 1,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             wrap,
   output logic             lockup
);

   // Elaboration-time parameter checks.
   if ((WIDTH < 3) || (WIDTH > 16)) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..16");
   end
   if ((STEPS < 1) || (STEPS > WIDTH)) begin : g_bad_steps
      $error("lfsr_gen: STEPS must be in 1..WIDTH");
   end
   if (DEFAULT_SEED == {WIDTH{1'b1}}) begin : g_bad_seed
      $error("lfsr_gen: DEFAULT_SEED must not be the all-ones lockup state");
   end

   // Tap mask per width; tap n corresponds to state bit n-1.
   function automatic logic [15:0] tap_mask(input int unsigned w);
      logic [15:0] m;
      case (w)
         32'd3:   m = 16'h0006;
         32'd4:   m = 16'h000C;
         32'd5:   m = 16'h0014;
         32'd6:   m = 16'h0030;
         32'd7:   m = 16'h0060;
         32'd8:   m = 16'h00B8;
         32'd9:   m = 16'h0110;
         32'd10:  m = 16'h0240;
         32'd11:  m = 16'h0500;
         32'd12:  m = 16'h0829;
         32'd13:  m = 16'h100D;
         32'd14:  m = 16'h2015;
         32'd15:  m = 16'h6000;
         32'd16:  m = 16'hD008;
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

   localparam logic [15:0]      TAP_MASK_FULL = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAP_MASK      = TAP_MASK_FULL[WIDTH-1:0];

   // One shift with XNOR feedback; XNOR keeps all-zeros legal and all-ones locked.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      logic fb;
      fb = ~(^(s & TAP_MASK));
      return {s[WIDTH-2:0], fb};
   endfunction

   // STEPS single steps chained combinationally so a transfer costs one clock.
   function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] t;
      t = s;
      for (int i = 0; i < int'(STEPS); i++) begin
         t = lfsr_step(t);
      end
      return t;
   endfunction

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] ref_seed_r;
   logic             out_valid_r;
   logic             wrap_r;
   logic             lockup_r;

   logic             fire_s;
   logic             seed_all_ones_s;
   logic [WIDTH-1:0] loaded_seed_s;
   logic [WIDTH-1:0] advanced_s;
   logic [WIDTH-1:0] state_nxt_s;
   logic [WIDTH-1:0] ref_seed_nxt_s;
   logic             valid_nxt_s;
   logic             wrap_nxt_s;
   logic             lockup_nxt_s;

   assign fire_s          = out_valid_r & out_ready;
   assign seed_all_ones_s = &seed;
   assign loaded_seed_s   = seed_all_ones_s ? DEFAULT_SEED : seed;
   assign advanced_s      = lfsr_advance(state_r);

   // Next-state selection: load overrides, then transfer, then valid raise/hold.
   always_comb begin
      state_nxt_s    = state_r;
      ref_seed_nxt_s = ref_seed_r;
      valid_nxt_s    = out_valid_r;
      wrap_nxt_s     = 1'b0;
      lockup_nxt_s   = 1'b0;
      if (load) begin
         state_nxt_s    = loaded_seed_s;
         ref_seed_nxt_s = loaded_seed_s;
         valid_nxt_s    = 1'b0;
         lockup_nxt_s   = seed_all_ones_s;
      end else if (fire_s) begin
         state_nxt_s = advanced_s;
         valid_nxt_s = enable;
         wrap_nxt_s  = (advanced_s == ref_seed_r);
      end else if (enable) begin
         valid_nxt_s = 1'b1;
      end else begin
         valid_nxt_s = out_valid_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= DEFAULT_SEED;
         ref_seed_r  <= DEFAULT_SEED;
         out_valid_r <= 1'b0;
         wrap_r      <= 1'b0;
         lockup_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ref_seed_r  <= ref_seed_nxt_s;
         out_valid_r <= valid_nxt_s;
         wrap_r      <= wrap_nxt_s;
         lockup_r    <= lockup_nxt_s;
      end
   end

   assign out_data  = state_r;
   assign out_valid = out_valid_r;
   assign wrap      = wrap_r;
   assign lockup    = lockup_r;

endmodule
